// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: decodes Opcode/Funct, sequences datapath
// enables, drives ALUControl and resolves branches/overflow traps.
module mips_multicycle_ctrl #(
    parameter bit EXC_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       ALUZero,
    input  logic       ALUOverflow,
    input  logic       MemReady,
    output logic [3:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       EPCWrite,
    output logic       CauseWrite,
    output logic       CauseCode,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_EXCEPT = 4'd12
    } state_t;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       src_a;
        logic [1:0] src_b;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       fetch_gate;
        logic       branch_gate;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       epc_write;
        logic       cause_write;
    } ctrl_t;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic CAUSE_OVF     = 1'b0;
    localparam logic CAUSE_ILLEGAL = 1'b1;

    state_t state_q, state_d;
    logic   cause_q, cause_d;
    ctrl_t  ctrl_q;

    function automatic logic funct_legal(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_XOR) || (fn == FN_NOR);
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        logic [3:0] a;
        case (fn)
            FN_ADD:  a = ALU_ADD;
            FN_SUB:  a = ALU_SUB;
            FN_AND:  a = ALU_AND;
            FN_OR:   a = ALU_OR;
            FN_XOR:  a = ALU_XOR;
            FN_NOR:  a = ALU_NOR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.src_b      = 2'b01;
                c.alu_ctrl   = ALU_ADD;
                c.fetch_gate = 1'b1;
            end
            S_DECODE: begin
                c.src_b    = 2'b11;
                c.alu_ctrl = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.src_a    = 1'b1;
                c.src_b    = 2'b10;
                c.alu_ctrl = ALU_ADD;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC: begin
                c.src_a    = 1'b1;
                c.alu_ctrl = funct_alu(fn);
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.src_a       = 1'b1;
                c.alu_ctrl    = ALU_SUB;
                c.pc_src      = 2'b01;
                c.branch_gate = 1'b1;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_EXCEPT: begin
                c.src_b       = 2'b01;
                c.alu_ctrl    = ALU_SUB;
                c.epc_write   = 1'b1;
                c.cause_write = 1'b1;
                c.pc_write    = 1'b1;
                c.pc_src      = 2'b11;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE: begin
                        if (funct_legal(Funct)) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d = S_EXCEPT;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_EXCEPT;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWR:  if (MemReady) state_d = S_FETCH;
            S_EXEC: begin
                if (EXC_ENABLE && ALUOverflow && (Funct == FN_ADD || Funct == FN_SUB)) begin
                    state_d = S_EXCEPT;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ADDIEX: begin
                if (EXC_ENABLE && ALUOverflow) begin
                    state_d = S_EXCEPT;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_ADDIWB;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Moore outputs are registered by decoding the next state, so they change
    // with the state register and reset straight to the FETCH decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cause_q <= 1'b0;
            ctrl_q  <= decode_ctrl(S_FETCH, '0);
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            ctrl_q  <= decode_ctrl(state_d, Funct);
        end
    end

    assign ALUControl = ctrl_q.alu_ctrl;
    assign ALUSrcA    = ctrl_q.src_a;
    assign ALUSrcB    = ctrl_q.src_b;
    assign IorD       = ctrl_q.iord;
    assign MemRead    = ctrl_q.mem_read;
    assign MemWrite   = ctrl_q.mem_write;
    assign IRWrite    = ctrl_q.fetch_gate & MemReady;
    assign RegWrite   = ctrl_q.reg_write;
    assign RegDst     = ctrl_q.reg_dst;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign PCWrite    = ctrl_q.pc_write | (ctrl_q.fetch_gate & MemReady) |
                        (ctrl_q.branch_gate & ALUZero);
    assign PCSource   = ctrl_q.pc_src;
    assign EPCWrite   = ctrl_q.epc_write;
    assign CauseWrite = ctrl_q.cause_write;
    assign CauseCode  = cause_q;
    assign State      = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS main control FSM: the producing end of the ALU control interface.
- Decodes Opcode/Funct and sequences datapath enables.
- Drives ALUControl codes to the ALU and consumes ALUZero/ALUOverflow for branch resolution and overflow exceptions.
- Sits between the instruction register and the shared-memory multicycle datapath; handshakes memory via MemReady.

Parameters:
- EXC_ENABLE, 1, 1 = ALUOverflow on add/sub/addi traps to EXCEPT; 0 = overflow ignored and writeback proceeds.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Opcode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- ALUZero  in  1  from ALU.
- ALUOverflow  in  1  from ALU.
- MemReady  in  1  memory completes the access this cycle.
- ALUControl  out  4  2=ADD, 6=SUB, 0=AND, 1=OR, 3=XOR, 4=NOR.
- ALUSrcA  out  1  0=PC, 1=regA.
- ALUSrcB  out  2  00=regB, 01=const 4, 10=signext imm, 11=imm<<2.
- IorD  out  1  memory address select, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegWrite  out  1  register file write.
- RegDst  out  1  1=rd, 0=rt.
- MemtoReg  out  1  writeback data select, 1=MDR.
- PCWrite  out  1  effective PC load enable, branch condition included.
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target, 11=exception vector.
- EPCWrite  out  1  EPC register load.
- CauseWrite  out  1  Cause register load.
- CauseCode  out  1  0=overflow, 1=illegal instruction.
- State  out  4  debug view of the current state.

Behaviour:
- State register: asynchronous clear to FETCH when rst_n=0. Outputs are Moore, decoded from the state only, except gating by MemReady and ALUZero as stated below.
- Default for every output is 0 unless listed. Reset value of every output is therefore the FETCH decode with MemReady as applied.
- CauseCode is a flop, reset 0, loaded on entry to EXCEPT.

States, codes and outputs:
- FETCH (0): MemRead=1, ALUSrcB=01, ALUControl=ADD, IRWrite=PCWrite=MemReady. Stay until MemReady, then go to DECODE.
- DECODE (1): ALUSrcB=11, ADD (branch target).
- DECODE next state by opcode: 0x00 R-type with legal funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor) -> EXEC. 0x23 lw or 0x2B sw -> MEMADR. 0x04 beq -> BRANCH. 0x08 addi -> ADDIEX. 0x02 j -> JUMP.
- DECODE, any other opcode or funct -> EXCEPT with CauseCode<=1.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ADD. Goes to MEMRD for lw, MEMWR for sw. Overflow ignored.
- MEMRD (3): IorD=1, MemRead=1. Hold until MemReady, then MEMWB.
- MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0. Then FETCH.
- MEMWR (5): IorD=1, MemWrite=1. Hold until MemReady, then FETCH.
- EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUControl mapped from funct (add->2, sub->6, and->0, or->1, xor->3, nor->4).
- EXEC next state: if EXC_ENABLE and ALUOverflow and funct is add/sub -> EXCEPT with CauseCode<=0; else ALUWB. Overflow is ignored for logical ops.
- ALUWB (7): RegWrite=1, RegDst=1. Then FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWrite=ALUZero. Then FETCH. Overflow ignored.
- JUMP (9): PCWrite=1, PCSource=10. Then FETCH.
- ADDIEX (10): ALUSrcA=1, ALUSrcB=10, ADD. Overflow with EXC_ENABLE -> EXCEPT, CauseCode<=0; else ADDIWB.
- ADDIWB (11): RegWrite=1, RegDst=0. Then FETCH.
- EXCEPT (12): ALUSrcA=0, ALUSrcB=01, SUB (EPC=PC-4), EPCWrite=1, CauseWrite=1, PCWrite=1, PCSource=11. Then FETCH.
- Codes 13-15: next state FETCH, all outputs 0.

Invariants:
- RegWrite is never asserted on a trapped instruction.
- MemRead and MemWrite are never both 1.
- rst_n low mid-access (MEMRD/MEMWR): State=0 and FETCH outputs appear immediately, with no clock needed.

Latency with MemReady=1:
- R-type and addi: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- beq and j: 3 cycles.
- Each MemReady-low cycle in FETCH/MEMRD/MEMWR adds 1.

Test Plan:
- Reset, then R-type add (Op=0x00, Funct=0x20), MemReady=1: State sequence 0,1,6,7,0. ALUControl=2 in EXEC. RegWrite=1 only in cycle 4, RegDst=1.
- lw (0x23), MemReady low for 2 cycles in MEMRD: 7-cycle sequence 0,1,2,3,3,3,4. MemRead+IorD held in MEMRD, MemtoReg=1 at writeback.
- beq (0x04): ALUZero=1 gives PCWrite=1, PCSource=01, ALUControl=6 in BRANCH. Repeat with ALUZero=0: PCWrite=0.
- sub (Funct=0x22) with ALUOverflow=1 in EXEC: next state 12, CauseCode=0, EPCWrite=CauseWrite=PCWrite=1, PCSource=11, RegWrite never 1. Repeat with nor (0x27) plus overflow: normal ALUWB. Repeat with EXC_ENABLE=0 plus add overflow: ALUWB.
- Illegal opcode 0x3F, then R-type funct 0x00: each goes DECODE -> EXCEPT with CauseCode=1.
- sw with MemReady=0, rst_n pulsed low mid-MEMWR, asynchronous to clk: MemWrite drops to 0, State=0, MemRead=1 immediately; normal fetch resumes after release.
